// File: rtl/fifo_write_arbiter.sv
// Purpose: merges NUM_REQ one-entry producer slots into a single fifo write port, round-robin.
// Latency: 2 cycles from a strobe into an empty slot to fifo_write_strobe; at most one write every 2 cycles.
// Backpressure: slots hold while fifo_space_available=0; strobes to full slots are dropped and flagged
//               (drop_count port present only with FIFO_ARB_DROP_COUNT_EN).
module fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int ID_BITS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_strobe,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_space_available,
    output logic                     fifo_write_strobe,
    output logic [WIDTH-1:0]         fifo_write_data,
    output logic [ID_BITS-1:0]       grant_id,
    output logic [NUM_REQ-1:0]       overflow,
    input  logic                     overflow_clear
`ifdef FIFO_ARB_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    logic [NUM_REQ-1:0] slot_full;
    logic [WIDTH-1:0]   slot_data [NUM_REQ];
    logic [ID_BITS-1:0] last;

    logic               issue_ok;
    logic               grant_vld;
    logic [ID_BITS-1:0] grant_idx;
    logic [NUM_REQ-1:0] drain;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] drop;

    assign req_ready = ~slot_full;

    // Back-to-back writes are blocked so a late space flag from the fifo is never overrun.
    assign issue_ok = fifo_space_available && !fifo_write_strobe;

    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!grant_vld && slot_full[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_BITS'(idx);
            end
        end
        if (!issue_ok) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        drain  = '0;
        accept = '0;
        drop   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drain[i]  = grant_vld && (grant_idx == ID_BITS'(i));
            accept[i] = req_strobe[i] && (!slot_full[i] || drain[i]);
            drop[i]   = req_strobe[i] && slot_full[i] && !drain[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full         <= '0;
            fifo_write_strobe <= 1'b0;
            fifo_write_data   <= '0;
            grant_id          <= '0;
            overflow          <= '0;
            last              <= ID_BITS'(NUM_REQ - 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= req_data[i*WIDTH +: WIDTH];
                end else if (drain[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end
            fifo_write_strobe <= grant_vld;
            if (grant_vld) begin
                fifo_write_data <= slot_data[grant_idx];
                grant_id        <= grant_idx;
                last            <= grant_idx;
            end
            // Clear wins over a same-cycle drop.
            overflow <= overflow_clear ? '0 : (overflow | drop);
        end
    end

`ifdef FIFO_ARB_DROP_COUNT_EN
    logic [3:0] drop_num;
    logic [8:0] drop_sum;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            drop_num = drop_num + {3'b000, drop[i]};
        end
        drop_sum = {1'b0, drop_count} + {5'b00000, drop_num};
    end

    always_ff @(posedge clk) begin
        if (reset || overflow_clear) begin
            drop_count <= '0;
        end else if (drop_sum[8]) begin
            drop_count <= 8'hff;
        end else begin
            drop_count <= drop_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed scenarios followed by random traffic, all checked against a slot-level reference model.
module tb_fifo_write_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [N-1:0]     req_strobe;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             fifo_space_available;
    logic             fifo_write_strobe;
    logic [W-1:0]     fifo_write_data;
    logic [1:0]       grant_id;
    logic [N-1:0]     overflow;
    logic             overflow_clear;
`ifdef FIFO_ARB_DROP_COUNT_EN
    logic [7:0]       drop_count;
`endif

    fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_BITS(2)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_strobe           (req_strobe),
        .req_data             (req_data),
        .req_ready            (req_ready),
        .fifo_space_available (fifo_space_available),
        .fifo_write_strobe    (fifo_write_strobe),
        .fifo_write_data      (fifo_write_data),
        .grant_id             (grant_id),
        .overflow             (overflow),
        .overflow_clear       (overflow_clear)
`ifdef FIFO_ARB_DROP_COUNT_EN
        ,
        .drop_count           (drop_count)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per-producer slots, a pointer, and the visible fifo-side outputs.
    bit       m_full [N];
    int       m_data [N];
    int       m_last;
    bit       m_wstb;
    int       m_wdata;
    int       m_gid;
    bit [N-1:0] m_ovf;
    int       m_cnt;

    int wlog[$];
    int glog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int g;
        int drops;
        bit [N-1:0] dropmask;
        g = -1;
        drops = 0;
        dropmask = '0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_full[i] = 0;
                m_data[i] = 0;
            end
            m_last = N - 1; m_wstb = 0; m_wdata = 0; m_gid = 0; m_ovf = '0; m_cnt = 0;
            return;
        end
        if (fifo_space_available && !m_wstb) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && m_full[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        if (g >= 0) begin
            m_wstb = 1; m_wdata = m_data[g]; m_gid = g; m_last = g; m_full[g] = 0;
        end else begin
            m_wstb = 0;
        end
        // A slot freed by this cycle's write can take a new byte at once.
        for (int i = 0; i < N; i++) begin
            if (req_strobe[i]) begin
                if (!m_full[i]) begin
                    m_full[i] = 1;
                    m_data[i] = int'(req_data[i*W +: W]);
                end else begin
                    drops++;
                    dropmask[i] = 1'b1;
                end
            end
        end
        if (overflow_clear) begin
            m_ovf = '0;
            m_cnt = 0;
        end else begin
            m_ovf = m_ovf | dropmask;
            m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
        end
    endtask

    task automatic check_all();
        bit [N-1:0] rdy;
        for (int i = 0; i < N; i++) rdy[i] = !m_full[i];
        chk("req_ready", 32'(req_ready), 32'(rdy));
        chk("write_strobe", 32'(fifo_write_strobe), 32'(m_wstb));
        chk("write_data", 32'(fifo_write_data), m_wdata);
        chk("grant_id", 32'(grant_id), m_gid);
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef FIFO_ARB_DROP_COUNT_EN
        chk("drop_count", 32'(drop_count), m_cnt);
`endif
        if (fifo_write_strobe === 1'b1) begin
            wlog.push_back(int'(fifo_write_data));
            glog.push_back(int'(grant_id));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_strobe = '0;
        req_data = '0;
        fifo_space_available = 1'b1;
        overflow_clear = 1'b0;

        // Reset state
        ticks(2);
        chk("rst_ready", 32'(req_ready), 32'hf);
        chk("rst_wstb", 32'(fifo_write_strobe), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;

        // Single write, two-cycle latency
        wlog.delete(); glog.delete();
        req_strobe = 4'b0100;
        req_data = 32'h005a_0000;
        tick();
        req_strobe = '0;
        tick();
        chk("t2_latency", 32'(fifo_write_strobe), 32'h1);
        ticks(4);
        chk("t2_count", wlog.size(), 1);
        chk("t2_data", wlog[0], 32'h5a);
        chk("t2_gid", glog[0], 2);

        // Round-robin from a fresh pointer, then a repeat
        do_reset();
        for (int rep = 0; rep < 2; rep++) begin
            wlog.delete(); glog.delete();
            req_strobe = 4'b1111;
            req_data = (rep == 0) ? 32'h1312_1110 : 32'h2322_2120;
            tick();
            req_strobe = '0;
            ticks(10);
            chk("t3_count", wlog.size(), 4);
            for (int i = 0; i < 4; i++) begin
                chk("t3_data", wlog[i], (rep == 0 ? 32'h10 : 32'h20) + i);
                chk("t3_gid", glog[i], i);
            end
        end

        // Fifo full: second strobe to a held slot is dropped
        wlog.delete(); glog.delete();
        fifo_space_available = 1'b0;
        req_strobe = 4'b0010; req_data = 32'h0000_3300;
        tick();
        req_data = 32'h0000_7700;
        tick();
        req_strobe = '0;
        ticks(3);
        chk("t4_ovf", 32'(overflow), 32'h2);
        chk("t4_nowrite", wlog.size(), 0);
`ifdef FIFO_ARB_DROP_COUNT_EN
        chk("t4_dropcnt", 32'(drop_count), 32'h1);
`endif
        fifo_space_available = 1'b1;
        ticks(4);
        chk("t4_count", wlog.size(), 1);
        chk("t4_data", wlog[0], 32'h33);

        // Capture into a slot on the cycle it is drained
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        chk("t5_clr", 32'(overflow), 32'h0);
        wlog.delete(); glog.delete();
        fifo_space_available = 1'b0;
        req_strobe = 4'b0001; req_data = 32'h0000_0055;
        tick();
        req_strobe = '0;
        tick();
        fifo_space_available = 1'b1;
        req_strobe = 4'b0001; req_data = 32'h0000_00aa;
        tick();
        req_strobe = '0;
        ticks(5);
        chk("t5_ovf", 32'(overflow), 32'h0);
        chk("t5_count", wlog.size(), 2);
        chk("t5_first", wlog[0], 32'h55);
        chk("t5_second", wlog[1], 32'haa);

        // Reset with slots full
        fifo_space_available = 1'b0;
        req_strobe = 4'b0111; req_data = 32'h0063_6261;
        tick();
        req_strobe = '0;
        wlog.delete(); glog.delete();
        fifo_space_available = 1'b1;
        do_reset();
        tick();
        chk("t6_ready", 32'(req_ready), 32'hf);
        chk("t6_nowrite", wlog.size(), 0);
        req_strobe = 4'b0011; req_data = 32'h0000_7271;
        tick();
        req_strobe = '0;
        ticks(6);
        chk("t6_count", wlog.size(), 2);
        chk("t6_first_gid", glog[0], 0);
        chk("t6_first", wlog[0], 32'h71);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(199) == 0);
            req_strobe = N'($urandom);
            req_data = $urandom;
            fifo_space_available = ($urandom_range(99) < 60);
            overflow_clear = ($urandom_range(29) == 0);
            tick();
        end
        reset = 1'b0; req_strobe = '0; overflow_clear = 1'b0;
        fifo_space_available = 1'b1;
        ticks(12);
        chk("final_ready", 32'(req_ready), 32'hf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
